div_32_seq: RTL and testbench

DIV_32_SEQ -- requirements
Module: div_32_seq

---
 rtl/div_32_seq_pkg.sv | 21 ++
 rtl/div_32_seq_if.sv | 41 ++++
 rtl/rca_32.sv | 25 ++
 rtl/div_32_seq.sv | 143 ++++++++++++++
 tb/tb_div_32_seq.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/div_32_seq_pkg.sv
// Shared constants and types for the sequential 32-bit unsigned divider.
//   Width     : operand/result width (only 32 is supported)
//   NumIter   : number of restoring steps per division
//   CntWidth  : width of the iteration counter
//   LastIter  : counter value of the final restoring step
//   state_e   : controller states (idle, calculating, result valid)
package div_32_seq_pkg;

    localparam int unsigned Width    = 32;
    localparam int unsigned NumIter  = 32;
    localparam int unsigned CntWidth = 5;

    localparam logic [CntWidth-1:0] LastIter = CntWidth'(NumIter - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/div_32_seq_if.sv
// Request/result bundle for div_32_seq.
//   master : drives start/dividend/divisor, observes busy/done/quotient/remainder/div_by_zero
//   slave  : the divider side of the same signals
interface div_32_seq_if
    import div_32_seq_pkg::*;
#(
    parameter int unsigned WIDTH = Width
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );

endinterface

// File: rtl/rca_32.sv
// 32-bit ripple-carry adder.
//   a_i, b_i : addends
//   cin_i    : carry into bit 0
//   sum_o    : a_i + b_i + cin_i, modulo 2^32
//   cout_o   : carry out of bit 31
module rca_32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);

    always_comb begin
        logic carry;
        carry = cin_i;
        sum_o = '0;
        for (int i = 0; i < 32; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end

endmodule

// File: rtl/div_32_seq.sv
// Sequential unsigned divider, one restoring step per clock, 32 steps per division.
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : div_32_seq_if slave port
//          start/dividend/divisor in; busy, done (1-cycle pulse), quotient, remainder,
//          div_by_zero out. Results hold from done until the next accepted start.
module div_32_seq
    import div_32_seq_pkg::*;
#(
    parameter int unsigned WIDTH = Width  // only 32 is supported
) (
    input  logic         clk,
    input  logic         rst,
    div_32_seq_if.slave  bus
);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    rem_q, rem_d;        // partial remainder
    logic [WIDTH-1:0]    quo_q, quo_d;        // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0]    div_q, div_d;        // latched divisor
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                dbz_q, dbz_d;
    logic [WIDTH-1:0]    quotient_q, quotient_d;
    logic [WIDTH-1:0]    remainder_q, remainder_d;

    logic [WIDTH:0]      rem_shift;
    logic [WIDTH-1:0]    trial;
    logic                trial_cout;
    logic                step_ok;
    logic [WIDTH-1:0]    rem_step;
    logic [WIDTH-1:0]    quo_step;

    // Trial subtraction R'[31:0] - D as R'[31:0] + ~D + 1.
    rca_32 u_rca (
        .a_i    (rem_shift[WIDTH-1:0]),
        .b_i    (~div_q),
        .cin_i  (1'b1),
        .sum_o  (trial),
        .cout_o (trial_cout)
    );

    // One restoring step. Bit 32 of R' set means R' >= 2^32 > D, so the subtraction
    // always succeeds and the wrapped 32-bit trial is the correct new remainder.
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        step_ok   = rem_shift[WIDTH] | trial_cout;
        rem_step  = step_ok ? trial : rem_shift[WIDTH-1:0];
        quo_step  = {quo_q[WIDTH-2:0], step_ok};
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    quo_d  = bus.dividend;
                    div_d  = bus.divisor;
                    rem_d  = '0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    dbz_d  = 1'b0;
                    if (bus.divisor == '0) begin
                        // Skip the iteration entirely and publish the fixed result.
                        state_d     = StDone;
                        done_d      = 1'b1;
                        dbz_d       = 1'b1;
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end

            StCalc: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastIter) begin
                    state_d     = StDone;
                    done_d      = 1'b1;
                    quotient_d  = quo_step;
                    remainder_d = rem_step;
                end
            end

            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_32_seq.sv
// Self-checking bench for div_32_seq: directed table, hand-written corner sequences
// and randomized operands checked against an arithmetic reference model.
module tb_div_32_seq;

    logic clk;
    logic rst;

    div_32_seq_if #(.WIDTH(32)) bus ();

    div_32_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain unsigned division with the divide-by-zero convention.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r,
                           output logic dbz, output int lat);
        if (b == 0) begin
            q   = 32'hFFFF_FFFF;
            r   = a;
            dbz = 1'b1;
            lat = 1;
        end else begin
            q   = a / b;
            r   = a % b;
            dbz = 1'b0;
            lat = 33;
        end
    endtask

    // Issue one division and check latency, results, busy and the single done pulse.
    // With wiggle set, operands change after acceptance and start is pulsed mid-CALC.
    task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                          input int elat, input bit wiggle);
        int   lat;
        bit   seen;
        bit   busy_ok;
        logic [31:0] q_seen;
        logic [31:0] r_seen;
        logic        dbz_seen;
        lat      = 0;
        seen     = 1'b0;
        busy_ok  = 1'b1;
        q_seen   = '0;
        r_seen   = '0;
        dbz_seen = 1'b0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (wiggle) begin
            bus.dividend = ~a;
            bus.divisor  = b + 32'd3;
        end
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (wiggle && c == 5) begin
                bus.start    = 1'b1;
                bus.dividend = 32'd999;
                bus.divisor  = 32'd3;
            end
            if (wiggle && c == 8) bus.start = 1'b0;
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.done) begin
                seen     = 1'b1;
                lat      = c;
                q_seen   = bus.quotient;
                r_seen   = bus.remainder;
                dbz_seen = bus.div_by_zero;
            end
        end
        bus.start = 1'b0;
        check({name, " latency"},   lat,      elat);
        check({name, " busy"},      busy_ok,  1);
        check({name, " quotient"},  q_seen,   eq);
        check({name, " remainder"}, r_seen,   er);
        check({name, " dbz"},       dbz_seen, edbz);
        @(negedge clk);
        check({name, " done_pulse"}, bus.done,      0);
        check({name, " busy_idle"},  bus.busy,      0);
        check({name, " hold_q"},     bus.quotient,  eq);
        check({name, " hold_r"},     bus.remainder, er);
        check({name, " hold_dbz"},   bus.div_by_zero, edbz);
    endtask

    vec_t tbl[6];

    initial begin
        logic [31:0] a, b, q, r;
        logic        dbz;
        int          lat;
        int          dones;

        tbl[0] = '{"100/7",      32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
        tbl[1] = '{"max/8000_0001", 32'hFFFF_FFFF, 32'h8000_0001, 32'd1,        32'h7FFF_FFFE,  1'b0, 33};
        tbl[2] = '{"5/0",        32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1};
        tbl[3] = '{"12345/12346", 32'd12345,     32'd12346,      32'd0,          32'd12345,      1'b0, 33};
        tbl[4] = '{"0/9",        32'd0,          32'd9,          32'd0,          32'd0,          1'b0, 33};
        tbl[5] = '{"max/1",      32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33};

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        check("reset busy",      bus.busy,        0);
        check("reset done",      bus.done,        0);
        check("reset quotient",  bus.quotient,    0);
        check("reset remainder", bus.remainder,   0);
        check("reset dbz",       bus.div_by_zero, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_div(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dbz,
                   tbl[i].lat, 1'b0);
        end

        // Reset mid-CALC: abort without done, outputs cleared, then a clean division.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset busy",      bus.busy,      0);
        check("midreset done",      bus.done,      0);
        check("midreset quotient",  bus.quotient,  0);
        check("midreset remainder", bus.remainder, 0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        check("midreset no activity", dones, 0);
        do_div("1000/10 after reset", 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 33, 1'b0);

        // Start pulsed and operands changed during CALC must not disturb the result.
        do_div("100/7 wiggle", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1'b1);

        // Reset wins over start on the same edge.
        @(negedge clk);
        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
        @(negedge clk);
        check("rst_prio busy", bus.busy, 0);
        check("rst_prio done", bus.done, 0);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("rst_prio still idle", bus.busy, 0);

        for (int n = 0; n < 100; n++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = $urandom_range(1, 255);
                2:       b = $urandom >> $urandom_range(0, 31);
                default: b = ($urandom_range(0, 1) == 0) ? 32'd0 : a;
            endcase
            ref_div(a, b, q, r, dbz, lat);
            do_div($sformatf("rand%0d %h/%h", n, a, b), a, b, q, r, dbz, lat, n[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
